// File: rtl/clock_enable_bank.sv
// clock_enable_bank
// Bank of NUM_CH programmable clock-enable dividers running off one master
// clock. Each channel produces a one-cycle tick every N+1 edges and a square
// wave that toggles on every tick. A divisor written while a channel runs is
// shadowed and only applied at the channel's next wrap, so no runt periods
// are ever produced. A global sync pulse realigns all running channels to
// phase 0. All outputs come straight from flops.
module clock_enable_bank #(
    parameter int                        NUM_CH   = 4,
    parameter int                        CNT_W    = 16,
    parameter logic [NUM_CH*CNT_W-1:0]   DIV_INIT = {16'd49999, 16'd49, 16'd1, 16'd0}
) (
    input  logic                                            clock_50Mhz,
    input  logic                                            reset_n,
    input  logic                                            cfg_we,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0]  cfg_ch,
    input  logic [CNT_W-1:0]                                cfg_div,
    input  logic                                            cfg_en,
    input  logic                                            sync_pulse,
    output logic [NUM_CH-1:0]                               tick,
    output logic [NUM_CH-1:0]                               sq,
    output logic [NUM_CH-1:0]                               pending
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch

        // Registered channel state
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] div_act;
        logic [CNT_W-1:0] div_shd;
        logic             en;
        logic             pend;
        logic             tick_q;
        logic             sq_q;

        // Next-state values
        logic [CNT_W-1:0] cnt_d;
        logic [CNT_W-1:0] div_act_d;
        logic [CNT_W-1:0] div_shd_d;
        logic             en_d;
        logic             pend_d;
        logic             tick_d;
        logic             sq_d;

        // Decoded helpers
        logic             wr;
        logic             en_nxt;
        logic             wrap;
        logic [CNT_W-1:0] shd_nxt;

        // A write addressed to a channel index that does not exist matches
        // no channel and is therefore dropped without side effects.
        assign wr      = cfg_we && (cfg_ch == CH_W'(i));
        assign en_nxt  = wr ? cfg_en  : en;
        assign shd_nxt = wr ? cfg_div : div_shd;
        assign wrap    = (cnt == div_act);

        // Next-state decode: disabled, disabling, sync, wrap, or plain count
        always_comb begin
            // NOTE: every output of this block gets a default first, so no
            // path through the if/else chain can leave a latch behind.
            cnt_d     = cnt;
            div_act_d = div_act;
            div_shd_d = shd_nxt;
            en_d      = en_nxt;
            pend_d    = pend;
            tick_d    = 1'b0;
            sq_d      = sq_q;

            if (!en) begin
                // Channel idle: the shadow feeds straight through, so a
                // write lands immediately and re-enable starts from it.
                cnt_d     = '0;
                sq_d      = 1'b0;
                div_act_d = shd_nxt;
                pend_d    = 1'b0;
            end else if (!en_nxt) begin
                // Being switched off by this write: park at phase 0.
                cnt_d  = '0;
                sq_d   = 1'b0;
                pend_d = 1'b1;
            end else if (sync_pulse) begin
                // Realign to phase 0. A write in the same cycle is folded in
                // via shd_nxt, so the new divisor is active from phase 0.
                cnt_d     = '0;
                sq_d      = 1'b0;
                div_act_d = shd_nxt;
                pend_d    = 1'b0;
            end else if (wrap) begin
                // End of period. The swap uses the shadow as it was before
                // this edge; a write arriving now stays pending.
                cnt_d  = '0;
                tick_d = 1'b1;
                sq_d   = ~sq_q;
                if (pend) begin
                    div_act_d = div_shd;
                end
                pend_d = wr;
            end else begin
                // cnt never passes div_act, so this cannot overflow even
                // with the all-ones divisor.
                cnt_d  = cnt + CNT_W'(1);
                pend_d = pend | wr;
            end
        end

        // Channel state registers with asynchronous reset to the init divisor
        always_ff @(posedge clock_50Mhz or negedge reset_n) begin
            // NOTE: this bank is a handful of flops, not a memory, so every
            // register is reset; otherwise X would leak onto tick/sq.
            if (!reset_n) begin
                cnt     <= '0;
                div_act <= DIV_INIT[i*CNT_W +: CNT_W];
                div_shd <= DIV_INIT[i*CNT_W +: CNT_W];
                en      <= 1'b1;
                pend    <= 1'b0;
                tick_q  <= 1'b0;
                sq_q    <= 1'b0;
            end else begin
                // NOTE: non-blocking assignments so every register samples
                // the pre-edge values regardless of statement order.
                cnt     <= cnt_d;
                div_act <= div_act_d;
                div_shd <= div_shd_d;
                en      <= en_d;
                pend    <= pend_d;
                tick_q  <= tick_d;
                sq_q    <= sq_d;
            end
        end

        assign tick[i]    = tick_q;
        assign sq[i]      = sq_q;
        assign pending[i] = pend;

    end : g_ch

endmodule

// File: tb/tb_clock_enable_bank.sv
// tb_clock_enable_bank
// Directed bench for clock_enable_bank with default parameters. A small phase
// model (origin edge and period per channel) gives the expected tick, square
// wave and pending values after every clock edge; configuration events are
// applied to the model by hand at the edges where they are driven.
module tb_clock_enable_bank;

    logic       clock_50Mhz = 1'b0;
    logic       reset_n;
    logic       cfg_we;
    logic [1:0] cfg_ch;
    logic [15:0] cfg_div;
    logic       cfg_en;
    logic       sync_pulse;
    logic [3:0] tick;
    logic [3:0] sq;
    logic [3:0] pending;

    int checks;
    int failures;
    int cur_k;

    // Phase model
    int         origin [4];
    int         per    [4];
    bit         en_m   [4];
    logic [3:0] tick_m;
    logic [3:0] sq_m;
    logic [3:0] pend_m;
    logic [3:0] pmask;

    clock_enable_bank dut (
        .clock_50Mhz (clock_50Mhz),
        .reset_n     (reset_n),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_div     (cfg_div),
        .cfg_en      (cfg_en),
        .sync_pulse  (sync_pulse),
        .tick        (tick),
        .sq          (sq),
        .pending     (pending)
    );

    initial forever #5 clock_50Mhz = ~clock_50Mhz;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s edge=%0d got=%b expected=%b", tag, cur_k, got, exp);
        end
    endtask

    task automatic write_cfg(input int ch, input int div, input bit en);
        cfg_we  = 1'b1;
        cfg_ch  = 2'(ch);
        cfg_div = 16'(div);
        cfg_en  = en;
    endtask

    task automatic model_reset();
        origin = '{0, 0, 0, 0};
        per    = '{0, 1, 49, 49999};
        en_m   = '{1'b1, 1'b1, 1'b1, 1'b1};
        tick_m = '0;
        sq_m   = '0;
        pend_m = '0;
    endtask

    task automatic model_sync(input int k);
        for (int i = 0; i < 4; i++) begin
            if (en_m[i]) begin
                origin[i] = k;
                sq_m[i]   = 1'b0;
            end
        end
    endtask

    task automatic model_step(input int k);
        for (int i = 0; i < 4; i++) begin
            automatic int j = k - origin[i];
            if (!en_m[i]) begin
                tick_m[i] = 1'b0;
                sq_m[i]   = 1'b0;
            end else begin
                tick_m[i] = (j > 0) && ((j % (per[i] + 1)) == 0);
                if (tick_m[i]) sq_m[i] = ~sq_m[i];
            end
        end
    endtask

    task automatic check_all(input string pfx);
        check({pfx, "tick"},    tick,              tick_m);
        check({pfx, "sq"},      sq,                sq_m);
        check({pfx, "pending"}, pending & pmask,   pend_m & pmask);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        cur_k      = -1;
        reset_n    = 1'b0;
        cfg_we     = 1'b0;
        cfg_ch     = '0;
        cfg_div    = '0;
        cfg_en     = 1'b0;
        sync_pulse = 1'b0;
        pmask      = 4'b1111;
        model_reset();

        // Held in reset: everything quiet
        repeat (3) @(negedge clock_50Mhz);
        check_all("rst_");

        // Release between edges, nothing has ticked yet
        reset_n = 1'b1;
        cur_k   = 0;
        check_all("rel_");

        // Phase 1: defaults, sync, pending divisor, disable/enable, write+sync,
        // write on a wrap edge with overwrite
        for (int k = 1; k <= 208; k++) begin
            cfg_we     = 1'b0;
            sync_pulse = 1'b0;
            case (k)
                65:  sync_pulse = 1'b1;
                86:  write_cfg(2, 9, 1'b1);
                132: write_cfg(1, 1, 1'b0);
                140: write_cfg(1, 3, 1'b1);
                160: begin sync_pulse = 1'b1; write_cfg(3, 4, 1'b1); end
                180: write_cfg(2, 7, 1'b1);
                184: write_cfg(2, 4, 1'b1);
                207: write_cfg(2, 2, 1'b1);
                default: ;
            endcase

            @(negedge clock_50Mhz);
            cur_k = k;

            case (k)
                65:  model_sync(k);
                86:  pend_m[2] = 1'b1;
                132: en_m[1] = 1'b0;
                140: begin en_m[1] = 1'b1; origin[1] = 140; per[1] = 3; end
                160: begin per[3] = 4; model_sync(k); end
                180: pend_m[2] = 1'b1;
                207: pend_m[2] = 1'b1;
                default: ;
            endcase

            model_step(k);

            // Pending divisor swaps in at the wrap that just ticked
            if (k == 115) begin origin[2] = 115; per[2] = 9; pend_m[2] = 1'b0; end
            if (k == 190) begin origin[2] = 190; per[2] = 4; pend_m[2] = 1'b0; end

            pmask = (k >= 132 && k <= 139) ? 4'b1101 : 4'b1111;
            check_all("p1_");
        end
        cfg_we = 1'b0;
        pmask  = 4'b1111;

        // Reset asserted between edges: outputs clear without a clock
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        cur_k = -2;
        check_all("arst_");

        repeat (2) @(negedge clock_50Mhz);
        reset_n = 1'b1;
        cur_k   = 0;
        check_all("rel2_");

        // Phase 2: default timing again, including the 50000-edge channel
        for (int k = 1; k <= 50005; k++) begin
            @(negedge clock_50Mhz);
            cur_k = k;
            model_step(k);
            if (k <= 120 || k >= 49990) check_all("p2_");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
